// File: rtl/i2s_transceiver_param.sv
// I2S / left- / right-justified master transceiver for the PMOD I2S2.
// Derives SCLK/LRCK from MCLK, buffers one playback pair, captures stereo pairs.
module i2s_transceiver_param #(
    parameter int DATA_WIDTH = 24,
    parameter int SLOT_WIDTH = 32,
    parameter int SCLK_DIV   = 8,
    parameter int MODE       = 0
) (
    input  logic                  MCLK,
    input  logic                  RST_N,
    output logic                  SCLK,
    output logic                  LRCK,
    output logic                  SDOUT,
    input  logic                  SDIN,
    input  logic [DATA_WIDTH-1:0] TX_DATA_L,
    input  logic [DATA_WIDTH-1:0] TX_DATA_R,
    input  logic                  TX_VALID,
    output logic                  TX_READY,
    output logic                  TX_UNDERRUN,
    output logic [DATA_WIDTH-1:0] RX_DATA_L,
    output logic [DATA_WIDTH-1:0] RX_DATA_R,
    output logic                  RX_VALID
);

    localparam int DB = $clog2(SCLK_DIV);
    localparam int BW = $clog2(SLOT_WIDTH);
    localparam int OFFSET = (MODE == 0) ? 1 :
                            (MODE == 1) ? 0 : SLOT_WIDTH - DATA_WIDTH;

    localparam logic [DB-1:0] D_LAST = DB'(SCLK_DIV - 1);
    localparam logic [DB-1:0] D_RISE = DB'(SCLK_DIV / 2 - 1);
    localparam logic [BW-1:0] B_LAST = BW'(SLOT_WIDTH - 1);
    localparam logic [BW-1:0] B_FIRST = BW'(OFFSET);
    localparam logic [BW-1:0] B_END = BW'(OFFSET + DATA_WIDTH - 1);
    localparam logic [BW:0] WIN_LEN = (BW + 1)'(DATA_WIDTH);

    generate
        if (DATA_WIDTH < 1 || SLOT_WIDTH < 2 || SCLK_DIV < 2 ||
            (SCLK_DIV % 2) != 0 || MODE < 0 || MODE > 2 ||
            DATA_WIDTH > SLOT_WIDTH - ((MODE == 0) ? 1 : 0)) begin : g_bad_params
            $error("i2s_transceiver_param: illegal parameter combination");
        end
    endgenerate

    logic [DB-1:0]         d;
    logic [BW-1:0]         b;
    logic                  c;
    logic [BW-1:0]         b_next;
    logic                  c_next;
    logic                  fall;
    logic                  rise;
    logic                  frame_start;
    logic [BW:0]           rel_tx;
    logic [BW:0]           rel_rx;
    logic                  win_tx;
    logic                  win_rx;

    logic                  buf_full;
    logic                  full_next;
    logic                  accept;
    logic [DATA_WIDTH-1:0] buf_l;
    logic [DATA_WIDTH-1:0] buf_r;
    logic [DATA_WIDTH-1:0] sh_l;
    logic [DATA_WIDTH-1:0] sh_r;
    logic [DATA_WIDTH-1:0] cur_l;
    logic [DATA_WIDTH-1:0] cur_r;
    logic [DATA_WIDTH-1:0] rx_l;
    logic [DATA_WIDTH-1:0] rx_r;
    logic                  cap;

    // Next bit/slot position and the SCLK edge strobes derived from d.
    always_comb begin
        fall   = (d == D_LAST);
        rise   = (d == D_RISE);
        b_next = b;
        c_next = c;
        if (fall) begin
            if (b == B_LAST) begin
                b_next = '0;
                c_next = ~c;
            end else begin
                b_next = b + BW'(1);
            end
        end
        frame_start = fall && (b_next == '0) && !c_next;
        // Window test by offset subtraction; bits before the window wrap large.
        rel_tx = {1'b0, b_next} - {1'b0, B_FIRST};
        rel_rx = {1'b0, b} - {1'b0, B_FIRST};
        win_tx = (rel_tx < WIN_LEN);
        win_rx = (rel_rx < WIN_LEN);
    end

    // Playback words as seen on this edge, including a frame-start reload.
    always_comb begin
        accept    = TX_VALID && TX_READY;
        cur_l     = sh_l;
        cur_r     = sh_r;
        full_next = buf_full;
        if (frame_start) begin
            cur_l     = buf_full ? buf_l : '0;
            cur_r     = buf_full ? buf_r : '0;
            full_next = 1'b0;
        end
        if (accept) begin
            full_next = 1'b1;
        end
    end

    // MCLK divider, bit counter and slot toggle.
    always_ff @(posedge MCLK or negedge RST_N) begin
        if (!RST_N) begin
            d <= '0;
            b <= '0;
            c <= 1'b0;
        end else begin
            d <= fall ? '0 : d + DB'(1);
            b <= b_next;
            c <= c_next;
        end
    end

    // Registered bit clock and word select.
    always_ff @(posedge MCLK or negedge RST_N) begin
        if (!RST_N) begin
            SCLK <= 1'b0;
            LRCK <= 1'b0;
        end else begin
            if (fall) begin
                SCLK <= 1'b0;
            end else if (rise) begin
                SCLK <= 1'b1;
            end
            if (fall && (b_next == '0)) begin
                LRCK <= c_next;
            end
        end
    end

    // One-pair playback buffer with underrun flag.
    always_ff @(posedge MCLK or negedge RST_N) begin
        if (!RST_N) begin
            buf_full    <= 1'b0;
            buf_l       <= '0;
            buf_r       <= '0;
            TX_READY    <= 1'b1;
            TX_UNDERRUN <= 1'b0;
        end else begin
            buf_full    <= full_next;
            TX_READY    <= !full_next;
            TX_UNDERRUN <= frame_start && !buf_full;
            if (accept) begin
                buf_l <= TX_DATA_L;
                buf_r <= TX_DATA_R;
            end
        end
    end

    // Serialise MSB first on falling SCLK edges inside the data window.
    always_ff @(posedge MCLK or negedge RST_N) begin
        if (!RST_N) begin
            sh_l  <= '0;
            sh_r  <= '0;
            SDOUT <= 1'b0;
        end else if (fall) begin
            sh_l  <= cur_l;
            sh_r  <= cur_r;
            SDOUT <= 1'b0;
            if (win_tx) begin
                if (c_next) begin
                    SDOUT <= cur_r[DATA_WIDTH-1];
                    sh_r  <= cur_r << 1;
                end else begin
                    SDOUT <= cur_l[DATA_WIDTH-1];
                    sh_l  <= cur_l << 1;
                end
            end
        end
    end

    // Deserialise on rising SCLK edges; publish the pair one MCLK later.
    always_ff @(posedge MCLK or negedge RST_N) begin
        if (!RST_N) begin
            rx_l      <= '0;
            rx_r      <= '0;
            cap       <= 1'b0;
            RX_DATA_L <= '0;
            RX_DATA_R <= '0;
            RX_VALID  <= 1'b0;
        end else begin
            if (rise && win_rx) begin
                if (c) begin
                    rx_r <= (rx_r << 1) | DATA_WIDTH'(SDIN);
                end else begin
                    rx_l <= (rx_l << 1) | DATA_WIDTH'(SDIN);
                end
            end
            cap      <= rise && c && (b == B_END);
            RX_VALID <= cap;
            if (cap) begin
                RX_DATA_L <= rx_l;
                RX_DATA_R <= rx_r;
            end
        end
    end

endmodule

// File: tb/tb_i2s_transceiver_param.sv
// Directed bench: three loopback instances (I2S, LJ, RJ) at default sizes.
// Expected values are hand-derived from frame timing (512 MCLK per frame).
module tb_i2s_transceiver_param;

    logic        mclk;
    logic        rst_n;
    logic        sclk [3];
    logic        lrck [3];
    logic        sdout [3];
    logic        tx_valid [3];
    logic        tx_ready [3];
    logic        tx_underrun [3];
    logic        rx_valid [3];
    logic [23:0] tx_l [3];
    logic [23:0] tx_r [3];
    logic [23:0] rx_l [3];
    logic [23:0] rx_r [3];

    int          n_tests;
    int          n_fail;
    int          cyc;
    int          rvc0;
    int          uc0;
    int          uc1;
    logic [63:0] s0;
    logic [63:0] s1;
    logic [63:0] s2;

    i2s_transceiver_param #(.MODE(0)) u_m0 (
        .MCLK(mclk), .RST_N(rst_n), .SCLK(sclk[0]), .LRCK(lrck[0]),
        .SDOUT(sdout[0]), .SDIN(sdout[0]),
        .TX_DATA_L(tx_l[0]), .TX_DATA_R(tx_r[0]), .TX_VALID(tx_valid[0]),
        .TX_READY(tx_ready[0]), .TX_UNDERRUN(tx_underrun[0]),
        .RX_DATA_L(rx_l[0]), .RX_DATA_R(rx_r[0]), .RX_VALID(rx_valid[0])
    );

    i2s_transceiver_param #(.MODE(1)) u_m1 (
        .MCLK(mclk), .RST_N(rst_n), .SCLK(sclk[1]), .LRCK(lrck[1]),
        .SDOUT(sdout[1]), .SDIN(sdout[1]),
        .TX_DATA_L(tx_l[1]), .TX_DATA_R(tx_r[1]), .TX_VALID(tx_valid[1]),
        .TX_READY(tx_ready[1]), .TX_UNDERRUN(tx_underrun[1]),
        .RX_DATA_L(rx_l[1]), .RX_DATA_R(rx_r[1]), .RX_VALID(rx_valid[1])
    );

    i2s_transceiver_param #(.MODE(2)) u_m2 (
        .MCLK(mclk), .RST_N(rst_n), .SCLK(sclk[2]), .LRCK(lrck[2]),
        .SDOUT(sdout[2]), .SDIN(sdout[2]),
        .TX_DATA_L(tx_l[2]), .TX_DATA_R(tx_r[2]), .TX_VALID(tx_valid[2]),
        .TX_READY(tx_ready[2]), .TX_UNDERRUN(tx_underrun[2]),
        .RX_DATA_L(rx_l[2]), .RX_DATA_R(rx_r[2]), .RX_VALID(rx_valid[2])
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    initial begin
        #500us;
        $display("FAIL watchdog: time limit reached at cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h (cyc %0d)",
                     tag, got, want, cyc);
        end
    endtask

    // Advance one MCLK, sample #1 after the edge, keep running tallies.
    task automatic tick();
        int p;
        @(posedge mclk);
        #1;
        cyc++;
        if (rx_valid[0]) rvc0++;
        if (tx_underrun[0]) uc0++;
        if (tx_underrun[1]) uc1++;
        if (cyc % 8 == 4) begin
            p = (cyc % 512) / 8;
            s0[63-p] = sdout[0];
            s1[63-p] = sdout[1];
            s2[63-p] = sdout[2];
        end
    endtask

    task automatic go_to(input int n);
        while (cyc < n) tick();
    endtask

    task automatic push(input int i, input logic [23:0] l,
                        input logic [23:0] r);
        tx_valid[i] = 1'b1;
        tx_l[i] = l;
        tx_r[i] = r;
    endtask

    initial begin
        n_tests = 0;
        n_fail = 0;
        cyc = 0;
        rvc0 = 0;
        uc0 = 0;
        uc1 = 0;
        s0 = '0;
        s1 = '0;
        s2 = '0;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tx_valid[i] = 1'b0;
            tx_l[i] = '0;
            tx_r[i] = '0;
        end

        repeat (3) @(posedge mclk);
        #1;
        chk("rst ready", tx_ready[0], 1);
        chk("rst sclk", sclk[0], 0);
        chk("rst lrck", lrck[0], 0);
        chk("rst sdout", sdout[0], 0);
        chk("rst rx", {rx_l[0], rx_r[0]}, 0);
        chk("rst flags", {rx_valid[0], tx_underrun[0]}, 0);

        @(negedge mclk);
        rst_n = 1'b1;
        cyc = 0;

        go_to(3);
        chk("sclk low e3", sclk[0], 0);
        go_to(4);
        chk("sclk rise e4", sclk[0], 1);
        go_to(8);
        chk("sclk fall e8", sclk[0], 0);
        go_to(10);
        push(0, 24'h800001, 24'h7FFFFE);
        push(1, 24'hA5A5A5, 24'h5A5A5A);
        push(2, 24'hFFFFFF, 24'hFFFFFF);
        go_to(11);
        chk("ready after push", tx_ready[0], 0);
        for (int i = 0; i < 3; i++) tx_valid[i] = 1'b0;
        go_to(12);
        chk("sclk rise e12", sclk[0], 1);

        go_to(255);
        chk("lrck left", lrck[0], 0);
        go_to(256);
        chk("lrck right", lrck[0], 1);
        go_to(511);
        chk("lrck right end", lrck[0], 1);
        go_to(512);
        chk("lrck period", lrck[0], 0);
        chk("i2s b0 zero", sdout[0], 0);
        chk("lj msb at start", sdout[1], 1);
        chk("rj b0 zero", sdout[2], 0);
        chk("ready frame1", tx_ready[0], 1);
        chk("no underrun f1", tx_underrun[0], 0);

        go_to(520);
        chk("i2s msb b1", sdout[0], 1);
        push(0, 24'h123456, 24'hFEDCBA);
        go_to(521);
        chk("hs1 ready", tx_ready[0], 0);
        tx_l[0] = 24'h0F0F0F;
        tx_r[0] = 24'hF0F0F0;
        go_to(576);
        chk("rj msb b8", sdout[2], 1);
        go_to(600);
        chk("ready held low", tx_ready[0], 0);

        go_to(957);
        chk("lj rxv", rx_valid[1], 1);
        chk("lj rx", {rx_l[1], rx_r[1]}, {24'hA5A5A5, 24'h5A5A5A});
        go_to(965);
        chk("i2s rxv", rx_valid[0], 1);
        chk("i2s rx", {rx_l[0], rx_r[0]}, {24'h800001, 24'h7FFFFE});
        go_to(966);
        chk("i2s rxv pulse", rx_valid[0], 0);
        go_to(1021);
        chk("rj rxv", rx_valid[2], 1);
        chk("rj rx", {rx_l[2], rx_r[2]}, {24'hFFFFFF, 24'hFFFFFF});
        go_to(1023);
        chk("i2s frame", s0, {1'b0, 24'h800001, 7'h0, 1'b0, 24'h7FFFFE, 7'h0});
        chk("lj frame", s1, {24'hA5A5A5, 8'h0, 24'h5A5A5A, 8'h0});
        chk("rj frame", s2, {8'h0, 24'hFFFFFF, 8'h0, 24'hFFFFFF});
        chk("i2s rxv count", rvc0, 2);

        go_to(1024);
        chk("ready at fs", tx_ready[0], 1);
        chk("m0 no underrun", tx_underrun[0], 0);
        chk("m1 underrun", tx_underrun[1], 1);
        go_to(1025);
        chk("hs2 ready", tx_ready[0], 0);
        tx_valid[0] = 1'b0;
        go_to(1030);
        push(1, 24'h000001, 24'h800000);
        go_to(1031);
        tx_valid[1] = 1'b0;
        go_to(1100);
        chk("m1 underrun cnt", uc1, 1);

        go_to(1477);
        chk("pair1 rx", {rx_l[0], rx_r[0]}, {24'h123456, 24'hFEDCBA});
        go_to(1536);
        chk("m0 no underrun f3", uc0, 0);
        go_to(1540);
        push(1, 24'h7FFFFF, 24'hC00003);
        go_to(1541);
        tx_valid[1] = 1'b0;
        go_to(1981);
        chk("lj q rx", {rx_l[1], rx_r[1]}, {24'h000001, 24'h800000});
        go_to(1989);
        chk("pair2 rx", {rx_l[0], rx_r[0]}, {24'h0F0F0F, 24'hF0F0F0});
        go_to(2493);
        chk("lj q2 rx", {rx_l[1], rx_r[1]}, {24'h7FFFFF, 24'hC00003});
        go_to(2559);
        chk("underrun zeros", s0, 0);
        go_to(2600);
        chk("underrun count", uc0, 2);
        push(0, 24'h111111, 24'h222222);
        go_to(2601);
        chk("ready pre rst", tx_ready[0], 0);
        tx_valid[0] = 1'b0;
        go_to(2900);
        chk("lj hold", rx_l[1], 24'h7FFFFF);
        go_to(2901);
        chk("mid sclk high", {sclk[0], lrck[0]}, 2'b11);

        rst_n = 1'b0;
        #1;
        chk("arst sclk lrck", {sclk[0], lrck[0]}, 0);
        chk("arst ready", tx_ready[0], 1);
        chk("arst rx", {rx_l[1], rx_r[1]}, 0);
        for (int k = 0; k < 3; k++) begin
            @(posedge mclk);
            #1;
            chk("rxv in rst", {rx_valid[0], rx_valid[1], rx_valid[2]}, 0);
        end

        @(negedge mclk);
        rst_n = 1'b1;
        cyc = 0;
        rvc0 = 0;
        go_to(3);
        chk("re sclk low", sclk[0], 0);
        go_to(4);
        chk("re sclk rise", sclk[0], 1);
        go_to(255);
        chk("re lrck left", lrck[0], 0);
        go_to(256);
        chk("re lrck right", lrck[0], 1);
        go_to(453);
        chk("re rxv", rx_valid[0], 1);
        go_to(460);
        chk("re rxv count", rvc0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/i2s_transceiver_param.md
Name: i2s_transceiver_param

Overview:
Parametrised I2S/PMOD I2S2 master-clocked transceiver. It derives SCLK and LRCK from MCLK and serialises stereo playback samples onto SDOUT. It deserialises capture samples from SDIN. Frame format is selectable: I2S, left-justified or right-justified. It adds a valid/ready playback buffer, a paired-stereo capture strobe, an underrun flag and async reset. It sits between the PMOD I2S2 pins and the FIR pipeline.

Parameters:
DATA_WIDTH, 24, sample bits per channel; must satisfy DATA_WIDTH <= SLOT_WIDTH - (MODE==0).
SLOT_WIDTH, 32, SCLK periods per channel slot; one frame = 2*SLOT_WIDTH SCLK periods.
SCLK_DIV, 8, MCLK cycles per SCLK period; even, >= 2.
MODE, 0, framing: 0 = I2S (1-bit delay), 1 = left-justified, 2 = right-justified.

Ports:
MCLK  in  1  master clock; all logic on posedge.
RST_N  in  1  asynchronous active-low reset.
SCLK  out  1  bit clock, registered.
LRCK  out  1  word select, registered; 0 = left slot, 1 = right slot.
SDOUT  out  1  serial playback data, registered.
SDIN  in  1  serial capture data.
TX_DATA_L  in  DATA_WIDTH  left playback sample, signed.
TX_DATA_R  in  DATA_WIDTH  right playback sample, signed.
TX_VALID  in  1  playback pair offered.
TX_READY  out  1  playback buffer empty; pair accepted when TX_VALID & TX_READY.
TX_UNDERRUN  out  1  one-MCLK pulse when a frame starts with an empty buffer.
RX_DATA_L  out  DATA_WIDTH  last captured left sample.
RX_DATA_R  out  DATA_WIDTH  last captured right sample.
RX_VALID  out  1  one-MCLK pulse when RX_DATA_L/R update together.

Behaviour:
- Counters:
  - d: 0..SCLK_DIV-1, increments every MCLK.
  - b: 0..SLOT_WIDTH-1, increments when d wraps.
  - c: toggles when b wraps.
  - Frame length = 2*SLOT_WIDTH*SCLK_DIV MCLK (512 at defaults).
- Clock outputs:
  - SCLK falls on the edge where d becomes 0 and rises where d becomes SCLK_DIV/2.
  - LRCK takes c on the falling-SCLK edge at b=0.
- Data window: OFFSET = 1 (I2S), 0 (LJ), SLOT_WIDTH-DATA_WIDTH (RJ). Bits b = OFFSET..OFFSET+DATA_WIDTH-1 carry data MSB first; other bit times drive SDOUT=0 and ignore SDIN.
- TX path:
  - SDOUT updates only on falling-SCLK edges.
  - Playback buffer is one stereo pair; TX_READY = buffer empty (registered).
  - Frame-start edge (c=0, b=0, d becomes 0):
    - Buffer full: move it to the L/R shift registers; buffer becomes empty.
    - Buffer empty: shift registers load 0 and TX_UNDERRUN pulses for that cycle.
  - In LJ mode, the SDOUT driven at the frame-start edge is the MSB of the newly loaded left word.
  - A handshake coinciding with an underrun frame start fills the buffer for the next frame, not the current one.
- RX path:
  - SDIN is sampled on rising-SCLK edges inside the data window and shifted MSB first.
  - After the last right-channel data bit is sampled, RX_DATA_L/RX_DATA_R update together on the next MCLK.
  - RX_VALID pulses for exactly 1 MCLK at that update.
  - Outputs hold until the next frame. There is no backpressure; the consumer must take data within one frame.
- Reset (RST_N low, async, any time including mid-frame):
  - d, b, c, SCLK, LRCK, SDOUT, shift registers, buffer, RX_DATA_L/R, RX_VALID, TX_UNDERRUN all go to 0; TX_READY goes to 1.
  - A partially captured frame is discarded with no RX_VALID.
  - After release, framing restarts at left slot b=0. The first SCLK rise is SCLK_DIV/2 MCLK after the first active edge.
- Illegal parameter combinations are rejected at elaboration.

Test Plan:
1. Reset release, defaults -> SCLK period 8 MCLK; first SCLK rise 4 MCLK after release; LRCK period 512 MCLK; TX_READY=1; all data outputs 0.
2. MODE=0, SDOUT looped to SDIN, push L=0x800001, R=0x7FFFFE before frame start -> SDOUT bit b=0 of the left slot is 0, MSB at b=1; RX_VALID single pulse that frame with RX_DATA_L=0x800001, RX_DATA_R=0x7FFFFE.
3. MODE=2, L=0xFFFFFF -> SDOUT 0 for b=0..7 of each slot, 1 for b=8..31; loopback captures 0xFFFFFF.
4. MODE=1, loopback, L=0xA5A5A5 -> MSB on SDOUT at the frame-start edge; capture equals 0xA5A5A5.
5. TX_VALID held high with two pairs -> first accepted immediately, TX_READY low until the next frame start, second accepted 1 MCLK later; no TX_UNDERRUN.
6. No TX_VALID for 2 frames -> TX_UNDERRUN pulses once per frame start, SDOUT all 0; then assert RST_N=0 at right slot b=10 -> outputs to reset values immediately, no RX_VALID, framing restarts on release.
